// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg
// Purpose : Shared constants, types and helpers for the AES plaintext loader.
//           Provides the byte/block geometry, the 128-bit block type, the
//           loader FSM state enum and the PKCS#7 pad-byte helper.
// Ports   : none (package)
// Config  : AES_LOADER_PKCS7_EN selects PKCS#7 padding in the loader top.
// ============================================================================
package aes_pkg;

    localparam int DATA_W    = 8;
    localparam int BLK_BYTES = 16;
    localparam int BLK_W     = DATA_W * BLK_BYTES;
    localparam int CNT_W     = 4;

    typedef logic [BLK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        PRESENT
    } loader_state_t;

    // PKCS#7 pads with the number of missing bytes; an empty remainder
    // (cnt == 0) yields a whole block of 0x10.
    function automatic logic [DATA_W-1:0] pkcs7_pad(input logic [CNT_W-1:0] cnt);
        return 8'(BLK_BYTES - int'(cnt));
    endfunction

endpackage

// File: rtl/aes_block_loader_block_packer.sv
// ============================================================================
// block_packer
// Purpose : Byte shift register that assembles a 128-bit plaintext block.
//           Byte number byte_cnt lands in the block so that the first byte
//           popped ends up in bits [127:120]. Also fills the tail of a
//           partial block with a pad byte, and holds the byte counter.
// Ports   :
//   i_clk       in   1    system clock
//   i_rst       in   1    synchronous active-high reset
//   i_pop       in   1    store i_data at position byte_cnt, advance counter
//   i_data      in   8    byte being popped from the FIFO
//   i_pad       in   1    fill positions byte_cnt..15 with i_padByte
//   i_padByte   in   8    pad value
//   i_clear     in   1    block handed off; restart counter at 0
//   o_block     out  128  assembled block
//   o_byteCnt   out  4    number of bytes stored in the current block
// ============================================================================
module block_packer
    import aes_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pop,
    input  logic [DATA_W-1:0]    i_data,
    input  logic                 i_pad,
    input  logic [DATA_W-1:0]    i_padByte,
    input  logic                 i_clear,
    output aes_block_t           o_block,
    output logic [CNT_W-1:0]     o_byteCnt
);

    // r_bytes[15] is bits [127:120], so byte position k lives at r_bytes[15-k].
    logic [BLK_BYTES-1:0][DATA_W-1:0] r_bytes;
    logic [CNT_W-1:0]                 r_byteCnt;

    // Store/pad the block and track how many bytes it holds. The counter
    // wraps from 15 to 0 on the 16th pop; after a padded block it is
    // explicitly cleared when the block is handed off.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bytes   <= '0;
            r_byteCnt <= '0;
        end else begin
            if (i_pop) begin
                // 15 - cnt is just the bitwise inverse for a 4-bit counter
                r_bytes[~r_byteCnt] <= i_data;
                r_byteCnt           <= r_byteCnt + 4'd1;
            end else if (i_pad) begin
                for (int k = 0; k < BLK_BYTES; k++) begin
                    if (4'(k) >= r_byteCnt) begin
                        r_bytes[BLK_BYTES-1-k] <= i_padByte;
                    end
                end
            end
            if (i_clear) begin
                r_byteCnt <= '0;
            end
        end
    end

    assign o_block   = r_bytes;
    assign o_byteCnt = r_byteCnt;

endmodule

// File: rtl/aes_block_loader.sv
// ============================================================================
// aes_block_loader
// Purpose : Pops bytes from a first-word-fall-through FIFO, packs 16 of them
//           into a 128-bit plaintext block and offers it to the AES core with
//           a valid/ready handshake. When the USB packet ends, a partial block
//           is padded and flushed so no plaintext stalls in the loader.
// Ports   :
//   i_clk            in   1    system clock
//   i_rst            in   1    synchronous active-high reset
//   i_fifo_r_data    in   8    FIFO head byte (valid while !i_fifo_empty)
//   i_fifo_empty     in   1    FIFO empty flag
//   o_fifo_r_enable  out  1    pop FIFO head this cycle
//   i_pkt_end        in   1    one-cycle pulse: packet's last byte written
//   o_blk_data       out  128  plaintext block, first byte in [127:120]
//   o_blk_valid      out  1    o_blk_data valid
//   i_blk_ready      in   1    AES core accepts the block
//   o_blk_last       out  1    block is the final one of the packet
//   o_busy           out  1    packet in progress
// Config  : AES_LOADER_PKCS7_EN defined -> PKCS#7 padding (pad = 16-count,
//           extra 0x10 block for 16-multiple or empty packets). Undefined ->
//           zero padding and no extra block for 16-multiple/empty packets.
// ============================================================================
module aes_block_loader
    import aes_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_W-1:0]    i_fifo_r_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_r_enable,
    input  logic                 i_pkt_end,
    output aes_block_t           o_blk_data,
    output logic                 o_blk_valid,
    input  logic                 i_blk_ready,
    output logic                 o_blk_last,
    output logic                 o_busy
);

    loader_state_t        r_state;
    loader_state_t        w_nextState;
    logic                 r_eopPend;
    logic                 r_blkLast;
    logic                 w_eopClr;
    logic                 w_pop;
    logic                 w_transfer;
    logic [CNT_W-1:0]     w_byteCnt;
    logic                 w_cntZero;
    logic                 w_cntLast;
    logic [DATA_W-1:0]    w_padByte;

    assign w_cntZero  = (w_byteCnt == '0);
    assign w_cntLast  = (w_byteCnt == 4'(BLK_BYTES-1));
    assign w_transfer = (r_state == PRESENT) && i_blk_ready;

`ifdef AES_LOADER_PKCS7_EN
    assign w_padByte = pkcs7_pad(w_byteCnt);
`else
    assign w_padByte = '0;
`endif

    block_packer u_packer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pop     (w_pop),
        .i_data    (i_fifo_r_data),
        .i_pad     (r_state == PAD),
        .i_padByte (w_padByte),
        .i_clear   (w_transfer),
        .o_block   (o_blk_data),
        .o_byteCnt (w_byteCnt)
    );

    // State register plus the two flags that travel with it. A pkt_end that
    // coincides with the clearing event wins, so a new packet end is never lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_eopPend <= 1'b0;
            r_blkLast <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (i_pkt_end) begin
                r_eopPend <= 1'b1;
            end else if (w_eopClr) begin
                r_eopPend <= 1'b0;
            end
            if (r_state == PAD) begin
                r_blkLast <= 1'b1;
            end else if (w_transfer) begin
                r_blkLast <= 1'b0;
            end
        end
    end

    // Next-state logic. An end of packet with no pending bytes either
    // produces a full pad block (PKCS#7) or is simply retired.
    always_comb begin
        w_nextState = r_state;
        w_eopClr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_fifo_empty) begin
                    w_nextState = FILL;
                end else if (r_eopPend && w_cntZero) begin
`ifdef AES_LOADER_PKCS7_EN
                    w_nextState = PAD;
`else
                    w_eopClr    = 1'b1;
`endif
                end
            end
            FILL: begin
                if (w_pop && w_cntLast) begin
                    w_nextState = PRESENT;
                end else if (i_fifo_empty && r_eopPend) begin
                    if (!w_cntZero) begin
                        w_nextState = PAD;
                    end else begin
`ifdef AES_LOADER_PKCS7_EN
                        w_nextState = PAD;
`else
                        w_nextState = IDLE;
                        w_eopClr    = 1'b1;
`endif
                    end
                end
            end
            PAD: begin
                w_nextState = PRESENT;
            end
            PRESENT: begin
                if (i_blk_ready) begin
                    if (r_blkLast) begin
                        w_nextState = IDLE;
                        w_eopClr    = 1'b1;
                    end else begin
                        w_nextState = FILL;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs. Popping is only allowed while filling, so backpressure from
    // the AES core is absorbed by the FIFO rather than by a skid buffer.
    always_comb begin
        w_pop           = (r_state == FILL) && !i_fifo_empty;
        o_fifo_r_enable = w_pop;
        o_blk_valid     = (r_state == PRESENT);
        o_blk_last      = (r_state == PRESENT) && r_blkLast;
        o_busy          = (r_state != IDLE) || r_eopPend;
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// ============================================================================
// tb_aes_block_loader
// Directed testbench for aes_block_loader. Models a first-word-fall-through
// FIFO, captures every accepted block and compares against hand-computed
// blocks. Honours AES_LOADER_PKCS7_EN for the padding-dependent expectations.
// ============================================================================
module tb_aes_block_loader;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    fifoRData;
    logic          fifoEmpty;
    logic          fifoREnable;
    logic          pktEnd = 1'b0;
    logic [127:0]  blkData;
    logic          blkValid;
    logic          blkReady = 1'b1;
    logic          blkLast;
    logic          busy;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    // FIFO model: writer pointer owned by the stimulus, reader pointer by the pop process
    logic [7:0] fifoMem [0:255];
    int         wrPtr = 0;
    int         rdPtr = 0;
    int         underflow = 0;

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoRData = fifoMem[rdPtr[7:0]];

    always @(posedge clk) begin
        if (fifoREnable) begin
            rdPtr <= rdPtr + 1;
            if (fifoEmpty) underflow <= underflow + 1;
        end
    end

    // Capture every accepted block
    logic [127:0] capData [0:31];
    logic         capLast [0:31];
    int           capCount = 0;

    always @(posedge clk) begin
        if (blkValid && blkReady && capCount < 32) begin
            capData[capCount] <= blkData;
            capLast[capCount] <= blkLast;
            capCount          <= capCount + 1;
        end
    end

    aes_block_loader dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_fifo_r_data   (fifoRData),
        .i_fifo_empty    (fifoEmpty),
        .o_fifo_r_enable (fifoREnable),
        .i_pkt_end       (pktEnd),
        .o_blk_data      (blkData),
        .o_blk_valid     (blkValid),
        .i_blk_ready     (blkReady),
        .o_blk_last      (blkLast),
        .o_busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Push n bytes first, first+step, ... into the FIFO model
    task automatic applyStimulus(input logic [7:0] first, input int n, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            fifoMem[wrPtr[7:0]] = first + 8'(i) * step;
            wrPtr = wrPtr + 1;
        end
    endtask

    task automatic pulsePktEnd();
        pktEnd = 1'b1;
        @(negedge clk);
        pktEnd = 1'b0;
    endtask

    task automatic waitBlocks(input int target, input string tag);
        int budget = 200;
        while (capCount < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, 128'(capCount >= target), 128'd1);
    endtask

    task automatic waitValid(input string tag);
        int budget = 200;
        while (!blkValid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, 128'(blkValid), 128'd1);
    endtask

    localparam logic [127:0] BLK_00 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BLK_20 = 128'h202122232425262728292a2b2c2d2e2f;
    localparam logic [127:0] BLK_30 = 128'h303132333435363738393a3b3c3d3e3f;
    localparam logic [127:0] BLK_40 = 128'h404142434445464748494a4b4c4d4e4f;
    localparam logic [127:0] BLK_50 = 128'h505152535455565758595a5b5c5d5e5f;
    localparam logic [127:0] BLK_70 = 128'h707172737475767778797a7b7c7d7e7f;
    localparam logic [127:0] BLK_90 = 128'h909192939495969798999a9b9c9d9e9f;
    localparam logic [127:0] BLK_10 = 128'h10101010101010101010101010101010;
`ifdef AES_LOADER_PKCS7_EN
    localparam logic [127:0] BLK_AA = 128'haaaaaaaaaa0b0b0b0b0b0b0b0b0b0b0b;
`else
    localparam logic [127:0] BLK_AA = 128'haaaaaaaaaa0000000000000000000000;
`endif

    initial begin
        int firstRen;
        int validAt;
        int renCount;
        int base;
        int validSeen;
        int unstable;
        int stallPops;
        logic [127:0] held;

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 128'(blkValid), 128'd0);
        checkOutput("rst_last",  128'(blkLast),  128'd0);
        checkOutput("rst_busy",  128'(busy),     128'd0);
        checkOutput("rst_ren",   128'(fifoREnable), 128'd0);
        checkOutput("rst_data",  blkData,        128'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- 1: 16 back-to-back bytes ----------------
        applyStimulus(8'h00, 16, 8'h01);
        firstRen = -1; validAt = -1; renCount = 0;
        for (int c = 1; c <= 40 && validAt < 0; c++) begin
            @(negedge clk);
            if (fifoREnable) begin
                renCount++;
                if (firstRen < 0) firstRen = c;
            end
            if (blkValid) validAt = c;
        end
        checkOutput("t1_pops",    128'(renCount), 128'd16);
        checkOutput("t1_latency", 128'(validAt - firstRen), 128'd16);
        checkOutput("t1_data",    blkData, BLK_00);
        checkOutput("t1_last",    128'(blkLast), 128'd0);
        @(negedge clk);
        checkOutput("t1_one_cycle", 128'(blkValid), 128'd0);
        checkOutput("t1_busy",      128'(busy), 128'd1);

        // ---------------- 2: 5-byte packet ----------------
        base = capCount;
        applyStimulus(8'hAA, 5, 8'h00);
        pulsePktEnd();
        waitBlocks(base + 1, "t2_block_seen");
        checkOutput("t2_data", capData[base], BLK_AA);
        checkOutput("t2_last", 128'(capLast[base]), 128'd1);
        repeat (2) @(negedge clk);
        checkOutput("t2_busy_low", 128'(busy), 128'd0);

        // ---------------- 3: 32-byte packet ----------------
        base = capCount;
        applyStimulus(8'h20, 32, 8'h01);
        pulsePktEnd();
        waitBlocks(base + 2, "t3_blocks_seen");
        checkOutput("t3_blk0",  capData[base],   BLK_20);
        checkOutput("t3_last0", 128'(capLast[base]), 128'd0);
        checkOutput("t3_blk1",  capData[base+1], BLK_30);
        checkOutput("t3_last1", 128'(capLast[base+1]), 128'd0);
`ifdef AES_LOADER_PKCS7_EN
        waitBlocks(base + 3, "t3_pad_block_seen");
        checkOutput("t3_blk2",  capData[base+2], BLK_10);
        checkOutput("t3_last2", 128'(capLast[base+2]), 128'd1);
        repeat (10) @(negedge clk);
        checkOutput("t3_block_count", 128'(capCount - base), 128'd3);
`else
        repeat (10) @(negedge clk);
        checkOutput("t3_block_count", 128'(capCount - base), 128'd2);
`endif
        checkOutput("t3_busy_low", 128'(busy), 128'd0);

        // ---------------- 4: backpressure ----------------
        base = capCount;
        blkReady = 1'b0;
        applyStimulus(8'h40, 16, 8'h01);
        applyStimulus(8'h50, 2, 8'h01);
        waitValid("t4_valid_seen");
        checkOutput("t4_data", blkData, BLK_40);
        held = blkData;
        stallPops = rdPtr;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!blkValid || blkData !== held || fifoREnable) unstable++;
        end
        checkOutput("t4_stall_stable", 128'(unstable), 128'd0);
        checkOutput("t4_stall_pops",   128'(rdPtr - stallPops), 128'd0);
        blkReady = 1'b1;
        applyStimulus(8'h52, 14, 8'h01);
        waitBlocks(base + 2, "t4_blocks_seen");
        checkOutput("t4_blk0", capData[base],   BLK_40);
        checkOutput("t4_blk1", capData[base+1], BLK_50);

        // ---------------- 5: FIFO runs dry mid-block ----------------
        base = capCount;
        applyStimulus(8'h70, 7, 8'h01);
        validSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (blkValid) validSeen++;
        end
        checkOutput("t5_no_valid", 128'(validSeen), 128'd0);
        checkOutput("t5_busy",     128'(busy), 128'd1);
        applyStimulus(8'h77, 9, 8'h01);
        waitBlocks(base + 1, "t5_block_seen");
        checkOutput("t5_data", capData[base], BLK_70);
        checkOutput("t5_last", 128'(capLast[base]), 128'd0);

        // ---------------- 6: reset mid-block ----------------
        base = rdPtr;
        applyStimulus(8'h80, 8, 8'h01);
        for (int c = 0; c < 100 && rdPtr < base + 8; c++) @(negedge clk);
        checkOutput("t6_eight_pops", 128'(rdPtr - base), 128'd8);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_valid", 128'(blkValid), 128'd0);
        checkOutput("t6_rst_busy",  128'(busy), 128'd0);
        checkOutput("t6_rst_ren",   128'(fifoREnable), 128'd0);
        checkOutput("t6_rst_data",  blkData, 128'd0);
        rst = 1'b0;
        base = capCount;
        applyStimulus(8'h90, 16, 8'h01);
        waitBlocks(base + 1, "t6_block_seen");
        checkOutput("t6_data", capData[base], BLK_90);

        // ---------------- 7: empty packet ----------------
        repeat (2) @(negedge clk);
        base = capCount;
        pulsePktEnd();
`ifdef AES_LOADER_PKCS7_EN
        waitBlocks(base + 1, "t7_block_seen");
        checkOutput("t7_data", capData[base], BLK_10);
        checkOutput("t7_last", 128'(capLast[base]), 128'd1);
`else
        repeat (10) @(negedge clk);
        checkOutput("t7_no_block", 128'(capCount - base), 128'd0);
`endif
        repeat (3) @(negedge clk);
        checkOutput("t7_busy_low", 128'(busy), 128'd0);

        checkOutput("fifo_underflow", 128'(underflow), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
